byte_uart_tx: RTL and testbench

Downstream consumer of the greeting/echo byte-stream generator. It takes that generator's 8-bit output, where a non-zero byte is data and 0x00 is idle, and buffers each byte in a small FIFO. It then serialises the bytes as UART 8N1 on a single tx pin. The upstream has no backpressure, so this block absorbs bursts and flags loss.

---
 rtl/byte_uart_pkg.sv | 25 ++
 rtl/byte_fifo.sv | 69 ++++++
 rtl/byte_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_byte_uart_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_uart_pkg.sv
// byte_uart_pkg: serializer state type, ASCII constants and the
// baud-counter width helper shared by the byte UART transmitter.
package byte_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } ser_state_e;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // Bits needed to hold div-1, i.e. smallest w with 2**w >= div.
    function automatic int unsigned baud_width(input int unsigned div);
        int unsigned w;
        w = 1;
        while (w < 31 && (32'd1 << w) < div) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous FIFO with a count register one bit wider
// than the pointers; push when full and pop when empty are ignored.
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/byte_uart_tx.sv
// byte_uart_tx: buffers a zero-idle byte stream and sends it as UART 8N1.
// Define UART_CRLF_EN to send a CR frame ahead of every LF byte.
module byte_uart_tx
    import byte_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned BW = baud_width(CLK_DIV);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

    ser_state_e    state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d;
    logic          busy_q;
    logic          overflow_q;

    logic          push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          baud_end;

`ifdef UART_CRLF_EN
    logic          cr_sent_q, cr_sent_d;
`endif

    assign push     = (in != 8'h00);
    assign baud_end = (baud_q == BAUD_MAX);

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .din_i   (in),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        fifo_pop = 1'b0;
`ifdef UART_CRLF_EN
        cr_sent_d = cr_sent_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
`ifdef UART_CRLF_EN
                    // LF stays at the head until its CR has gone out.
                    if (fifo_head == ASCII_LF && !cr_sent_q) begin
                        shreg_d   = ASCII_CR;
                        cr_sent_d = 1'b1;
                    end else begin
                        fifo_pop  = 1'b1;
                        shreg_d   = fifo_head;
                        cr_sent_d = 1'b0;
                    end
`else
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_head;
`endif
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase

        // Line level follows the state being entered, so tx is glitch-free.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[bit_d];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            busy_q     <= (state_q != ST_IDLE) || (fifo_count != '0);
            if (push && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef UART_CRLF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cr_sent_q <= 1'b0;
        end else begin
            cr_sent_q <= cr_sent_d;
        end
    end
`endif

endmodule

// File: tb/tb_byte_uart_tx.sv
// tb_byte_uart_tx: frame-level reference model feeds a scoreboard of
// expected bytes and start cycles; a line monitor decodes tx and checks.
module tb_byte_uart_tx;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FRAME = 10 * DIV;
    localparam int unsigned LIMIT = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_b = 8'h00;
    logic       tx;
    logic       busy;
    logic       overflow;

    byte_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_b),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        int unsigned t;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_fifo[$];
    int unsigned cyc    = 0;
    int unsigned m_free = 0;
    bit          m_cr   = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          crlf   = 1'b0;
    bit          full_b;
    logic [7:0]  hb;

    int n_chk  = 0;
    int n_pass = 0;
    int frames = 0;

    bit          mon_act = 1'b0;
    int unsigned mon_t;
    int unsigned mon_ph;
    int unsigned idx;
    logic [7:0]  mon_b;
    exp_t        e;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    task automatic clear_model();
        m_fifo.delete();
        exp_q.delete();
        m_free = 0;
        m_cr   = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Frame-level model: one pop per free serializer slot, slot = frame + 1 idle.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            full_b = (m_fifo.size() == DEPTH);
            if (m_fifo.size() != 0 && cyc >= m_free) begin
                if (crlf && m_fifo[0] == 8'h0A && !m_cr) begin
                    hb   = 8'h0D;
                    m_cr = 1'b1;
                end else begin
                    hb   = m_fifo.pop_front();
                    m_cr = 1'b0;
                end
                exp_q.push_back('{hb, cyc});
                m_free = cyc + FRAME + 1;
            end
            if (in_b != 8'h00) begin
                if (full_b) m_ovf = 1'b1;
                else m_fifo.push_back(in_b);
            end
        end
    end

    // Line monitor: mid-bit sampling of each frame, then scoreboard pop.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            mon_act = 1'b0;
        end else begin
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (!mon_act) begin
                if (tx == 1'b0) begin
                    mon_act = 1'b1;
                    mon_t   = cyc;
                    mon_ph  = 0;
                    mon_b   = 8'h00;
                end
            end else begin
                mon_ph++;
                if (mon_ph % DIV == DIV / 2) begin
                    idx = mon_ph / DIV;
                    if (idx == 0) begin
                        check("start bit", 32'(tx), 32'd0);
                    end else if (idx <= 8) begin
                        mon_b[idx-1] = tx;
                    end else begin
                        check("stop bit", 32'(tx), 32'd1);
                        frames++;
                        check("frame expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("frame byte", 32'(mon_b), 32'(e.b));
                            check("frame start cycle", mon_t, e.t);
                        end
                        mon_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_b = b;
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while (i < LIMIT && (exp_q.size() != 0 || m_fifo.size() != 0
                             || mon_act || busy)) begin
            @(negedge clk);
            i++;
        end
        check({nm, " drained"}, 32'(i < LIMIT), 32'd1);
        @(negedge clk);
        check({nm, " tx idle"}, 32'(tx), 32'd1);
        check({nm, " busy idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] hello [6];
    int         f0;
    int         bcnt;
    int         blen;

    initial begin
`ifdef UART_CRLF_EN
        crlf = 1'b1;
`endif
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
        rst   = 1'b0;
        in_b  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b1;

        // Single byte: 41 busy cycles, one frame.
        f0   = frames;
        bcnt = 0;
        send(8'h48);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_b = 8'h00;
            if (busy) bcnt++;
        end
        check("busy cycles", bcnt, 32'd41);
        drain("single");
        check("single frames", frames - f0, 32'd1);

        // Back-to-back burst.
        f0 = frames;
        for (int i = 0; i < 6; i++) send(hello[i]);
        send(8'h00);
        drain("hello");
        check("hello frames", frames - f0, 32'd6);
        check("hello overflow", 32'(overflow), 32'd0);

        // Idle zeros are never framed.
        f0 = frames;
        send(8'h41);
        repeat (3) send(8'h00);
        send(8'h42);
        send(8'h00);
        drain("interleave");
        check("interleave frames", frames - f0, 32'd2);

        // LF handling depends on the build.
        f0 = frames;
        send(8'h0A);
        send(8'h00);
        drain("lf");
        check("lf frames", frames - f0, crlf ? 32'd2 : 32'd1);

        // Overflow: 10-byte burst, last one dropped.
        f0 = frames;
        for (int i = 0; i < 10; i++) send(8'h31 + 8'(i));
        send(8'h00);
        check("burst overflow set", 32'(overflow), 32'd1);
        drain("burst");
        check("burst frames", frames - f0, 32'd9);
        check("burst overflow sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a frame.
        send(8'h55);
        send(8'h00);
        repeat (14) @(negedge clk);
        check("busy mid frame", 32'(busy), 32'd1);
        #1;
        rst = 1'b0;
        clear_model();
        #1;
        check("mid reset tx", 32'(tx), 32'd1);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        f0  = frames;
        send(8'h41);
        send(8'h00);
        drain("post reset");
        check("post reset frames", frames - f0, 32'd1);

        // Randomised traffic: sparse bytes plus occasional bursts.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                blen = $urandom_range(2, 12);
                for (int j = 0; j < blen; j++) begin
                    send(8'($urandom_range(1, 255)));
                end
            end else if ($urandom_range(0, 9) == 0) begin
                send(8'($urandom_range(1, 255)));
            end else begin
                send(8'h00);
            end
        end
        send(8'h00);
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
